// File: rtl/ika9958_regctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ika9958_regctrl                                              |
// | Description : CPU port #0-#3 write sequencer for the IKA9958 register file |
// |               and VRAM address setup. Handles the port #1 two-byte latch,  |
// |               port #3 indirect writes through the R#17 pointer, and        |
// |               fixed-zero bit masking. Optional palette port sequencer on   |
// |               port #2 when IKA9958_PALETTE_PORT_EN is defined.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ika9958_regctrl (
   input  logic        i_EMUCLK,
   input  logic        i_RST_n,
   input  logic        i_CPU_WR,
   input  logic        i_CPU_RD,
   input  logic [1:0]  i_CPU_PORT,
   input  logic [7:0]  i_CPU_DI,
   output logic        o_REG_WE,
   output logic [5:0]  o_REG_ADDR,
   output logic [7:0]  o_REG_DATA,
   output logic        o_VADDR_LD,
   output logic [13:0] o_VADDR,
   output logic        o_VADDR_WR,
   output logic [5:0]  o_R17_PTR
`ifdef IKA9958_PALETTE_PORT_EN
   ,
   output logic        o_PAL_WE,
   output logic [3:0]  o_PAL_ADDR,
   output logic [8:0]  o_PAL_DATA
`endif
);

   // Registers numbered at or above this limit do not exist in the file.
   localparam logic [5:0] c_reg_limit = 6'd47;
   localparam logic [5:0] c_reg_ptr   = 6'd17;
   localparam logic [5:0] c_reg_pal   = 6'd16;

   typedef enum logic [0:0] {
      P1_IDLE    = 1'b0,
      P1_LATCHED = 1'b1
   } p1_state_t;

   p1_state_t   p1_q, p1_d;
   logic [7:0]  first_q, first_d;
   logic [5:0]  ptr_q, ptr_d;
   logic        aii_q, aii_d;
   logic        reg_we_q, reg_we_d;
   logic [5:0]  reg_addr_q, reg_addr_d;
   logic [7:0]  reg_data_q, reg_data_d;
   logic        vaddr_ld_q, vaddr_ld_d;
   logic [13:0] vaddr_q, vaddr_d;
   logic        vaddr_wr_q, vaddr_wr_d;
`ifdef IKA9958_PALETTE_PORT_EN
   logic        pal_phase_q, pal_phase_d;
   logic [7:0]  pal_first_q, pal_first_d;
   logic [3:0]  pal_ptr_q, pal_ptr_d;
   logic        pal_we_q, pal_we_d;
   logic [3:0]  pal_addr_q, pal_addr_d;
   logic [8:0]  pal_data_q, pal_data_d;
`endif

   logic       w_wr;
   logic       w_rd;
   logic [5:0] w_p1_addr;

   // Bits hardwired to zero in the register file are cleared on the way out.
   function automatic logic [7:0] mask_data(input logic [5:0] addr, input logic [7:0] data);
      logic [7:0] m;
      m = data;
      if (addr == 6'd9)  m = data & 8'hCE;
      if (addr == 6'd15) m = data & 8'hBF;
      return m;
   endfunction

   // A write wins over a simultaneous read.
   assign w_wr      = i_CPU_WR;
   assign w_rd      = i_CPU_RD & ~i_CPU_WR;
   assign w_p1_addr = i_CPU_DI[5:0];

   // Command decode: next state of the port FSM, pointer and output registers.
   always_comb begin
      p1_d       = p1_q;
      first_d    = first_q;
      ptr_d      = ptr_q;
      aii_d      = aii_q;
      reg_we_d   = 1'b0;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      vaddr_ld_d = 1'b0;
      vaddr_d    = vaddr_q;
      vaddr_wr_d = vaddr_wr_q;
`ifdef IKA9958_PALETTE_PORT_EN
      pal_phase_d = pal_phase_q;
      pal_first_d = pal_first_q;
      pal_ptr_d   = pal_ptr_q;
      pal_we_d    = 1'b0;
      pal_addr_d  = pal_addr_q;
      pal_data_d  = pal_data_q;
`endif
      if (w_wr) begin
         case (i_CPU_PORT)
            2'd1: begin
               if (p1_q == P1_IDLE) begin
                  first_d = i_CPU_DI;
                  p1_d    = P1_LATCHED;
               end else begin
                  p1_d = P1_IDLE;
                  if (i_CPU_DI[7]) begin
                     if (w_p1_addr < c_reg_limit) begin
                        reg_we_d   = 1'b1;
                        reg_addr_d = w_p1_addr;
                        reg_data_d = mask_data(w_p1_addr, first_q);
                     end
                     if (w_p1_addr == c_reg_ptr) begin
                        ptr_d = first_q[5:0];
                        aii_d = first_q[7];
                     end
`ifdef IKA9958_PALETTE_PORT_EN
                     if (w_p1_addr == c_reg_pal) begin
                        pal_ptr_d   = first_q[3:0];
                        pal_phase_d = 1'b0;
                     end
`endif
                  end else begin
                     vaddr_ld_d = 1'b1;
                     vaddr_d    = {i_CPU_DI[5:0], first_q};
                     vaddr_wr_d = i_CPU_DI[6];
                  end
               end
            end
            2'd3: begin
               // Indirect write through the pointer; R#17 itself is not reachable.
               if ((ptr_q < c_reg_limit) && (ptr_q != c_reg_ptr)) begin
                  reg_we_d   = 1'b1;
                  reg_addr_d = ptr_q;
                  reg_data_d = mask_data(ptr_q, i_CPU_DI);
               end
               if (!aii_q) ptr_d = ptr_q + 6'd1;
            end
            2'd2: begin
               p1_d = P1_IDLE;
`ifdef IKA9958_PALETTE_PORT_EN
               if (!pal_phase_q) begin
                  pal_first_d = i_CPU_DI;
                  pal_phase_d = 1'b1;
               end else begin
                  pal_we_d    = 1'b1;
                  pal_addr_d  = pal_ptr_q;
                  pal_data_d  = {pal_first_q[6:4], i_CPU_DI[2:0], pal_first_q[2:0]};
                  pal_ptr_d   = pal_ptr_q + 4'd1;
                  pal_phase_d = 1'b0;
               end
`endif
            end
            default: p1_d = P1_IDLE;
         endcase
      end else if (w_rd && (i_CPU_PORT[1] == 1'b0)) begin
         // Reads of port #0 or #1 abandon a half-written port #1 pair.
         p1_d = P1_IDLE;
      end
   end

   // State and output registers.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         p1_q       <= P1_IDLE;
         first_q    <= 8'd0;
         ptr_q      <= 6'd0;
         aii_q      <= 1'b0;
         reg_we_q   <= 1'b0;
         reg_addr_q <= 6'd0;
         reg_data_q <= 8'd0;
         vaddr_ld_q <= 1'b0;
         vaddr_q    <= 14'd0;
         vaddr_wr_q <= 1'b0;
`ifdef IKA9958_PALETTE_PORT_EN
         pal_phase_q <= 1'b0;
         pal_first_q <= 8'd0;
         pal_ptr_q   <= 4'd0;
         pal_we_q    <= 1'b0;
         pal_addr_q  <= 4'd0;
         pal_data_q  <= 9'd0;
`endif
      end else begin
         p1_q       <= p1_d;
         first_q    <= first_d;
         ptr_q      <= ptr_d;
         aii_q      <= aii_d;
         reg_we_q   <= reg_we_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         vaddr_ld_q <= vaddr_ld_d;
         vaddr_q    <= vaddr_d;
         vaddr_wr_q <= vaddr_wr_d;
`ifdef IKA9958_PALETTE_PORT_EN
         pal_phase_q <= pal_phase_d;
         pal_first_q <= pal_first_d;
         pal_ptr_q   <= pal_ptr_d;
         pal_we_q    <= pal_we_d;
         pal_addr_q  <= pal_addr_d;
         pal_data_q  <= pal_data_d;
`endif
      end
   end

   assign o_REG_WE   = reg_we_q;
   assign o_REG_ADDR = reg_addr_q;
   assign o_REG_DATA = reg_data_q;
   assign o_VADDR_LD = vaddr_ld_q;
   assign o_VADDR    = vaddr_q;
   assign o_VADDR_WR = vaddr_wr_q;
   assign o_R17_PTR  = ptr_q;
`ifdef IKA9958_PALETTE_PORT_EN
   assign o_PAL_WE   = pal_we_q;
   assign o_PAL_ADDR = pal_addr_q;
   assign o_PAL_DATA = pal_data_q;
`endif

endmodule
`default_nettype wire

// File: doc/ika9958_regctrl.md
# ika9958_regctrl

Register write sequencer for the IKA9958 CPU interface. Decodes CPU accesses on ports #0–#3 into single-cycle write commands for the VDP register file and VRAM address setup. Covers the port #1 two-byte latch, port #3 indirect access with the R#17 pointer and auto-increment, and fixed-zero bit masking. Sits between the CPU bus synchronizer and the register-file storage that feeds `IKA9958_if_reg`.

## Interface
- Parameters: none.
- `i_EMUCLK` in 1: master clock, sole clock domain.
- `i_RST_n` in 1: reset, asynchronous, active-low.
- `i_CPU_WR` in 1: one-cycle write strobe, already synchronized to `i_EMUCLK`.
- `i_CPU_RD` in 1: one-cycle read strobe, already synchronized.
- `i_CPU_PORT` in 2: port select, sampled with a strobe.
- `i_CPU_DI` in 8: write data, sampled with `i_CPU_WR`.
- `o_REG_WE` in→out 1: register-file write pulse, one cycle.
- `o_REG_ADDR` out 6: register number.
- `o_REG_DATA` out 8: register data, masked.
- `o_VADDR_LD` out 1: VRAM address load pulse, one cycle.
- `o_VADDR` out 14: VRAM address low 14 bits.
- `o_VADDR_WR` out 1: 1 = address set up for write, 0 = for read (pre-fetch).
- `o_R17_PTR` out 6: current indirect pointer, for debug.
- `o_PAL_WE` / `o_PAL_ADDR[3:0]` / `o_PAL_DATA[8:0]`: palette write port. Present only with `IKA9958_PALETTE_PORT_EN`.

## Operation
- **Port #1 FSM.** States are `P1_IDLE` and `P1_LATCHED`.
  - Write in `P1_IDLE`: latch `i_CPU_DI` into `first`, go to `P1_LATCHED`.
  - Write in `P1_LATCHED` with DI[7]=1: register write. `o_REG_ADDR`=DI[5:0], data=`first`. DI[6] is ignored. Go to `P1_IDLE`.
  - Write in `P1_LATCHED` with DI[7]=0: address setup. `o_VADDR`={DI[5:0],`first`}, `o_VADDR_WR`=DI[6]. Pulse `o_VADDR_LD`. Go to `P1_IDLE`.
  - A read of port #1, or any access to port #0, forces `P1_IDLE` and discards `first`.
- **Port #3.** A write targets register `o_R17_PTR`.
  - When R#17 bit7 (AII) is 0, the pointer increments after the write, 63 wraps to 0.
  - When AII is 1, the pointer holds.
  - An indirect write whose target is 17 is suppressed (no `o_REG_WE`); the pointer still increments.
- **R#17 shadow.** A port #1 register write to R#17 loads the pointer from data[5:0] and AII from data[7].
- **Address range.** Writes to register numbers 47–63 from any path produce no `o_REG_WE`. Shadow and pointer side effects still apply.
- **Masking, applied on `o_REG_DATA`.**
  - R#9: bit0 and bits[5:4] forced to 0.
  - R#15: bit6 forced to 0.
  - All other bits pass through.
- **Simultaneous strobes.** If `i_CPU_WR` and `i_CPU_RD` are both high, the write is processed and the read is ignored.
- **Reset values.**
  - All pulse outputs 0.
  - `o_REG_ADDR`=0, `o_REG_DATA`=0, `o_VADDR`=0, `o_VADDR_WR`=0.
  - Pointer=0, AII=0, FSM=`P1_IDLE`.
- **Reset mid-sequence** discards any latched first byte.

## Timing
- All outputs are registered.
- Latency: a strobe in cycle N produces its pulse and data in cycle N+1.
- Address and data outputs hold until the next command.
- `o_R17_PTR` updates in cycle N+1, together with the write it follows.
- Back-to-back strobes, one per cycle, are accepted without loss. Each strobe is processed against the state left by the previous one.
- `o_REG_WE` and `o_VADDR_LD` are never high in the same cycle.

## Configuration
- Macro: `IKA9958_PALETTE_PORT_EN`.
- **Defined:** port #2 is a two-byte palette sequencer with a 4-bit R#16 pointer.
  - First byte is latched.
  - Second byte completes the write: `o_PAL_WE` pulses with `o_PAL_DATA`={first[6:4] R, second[2:0] G, first[2:0] B} and `o_PAL_ADDR`=pointer.
  - The pointer then increments mod 16.
  - A port #1 write to R#16 loads the pointer from data[3:0] and resets the palette phase.
  - Latency matches the other paths (N+1).
- **Undefined:** the palette ports are absent. Port #2 writes are ignored, apart from resetting the port #1 FSM to `P1_IDLE`.

## Test plan
1. Port #1 write 0x5A then 0x87 → one `o_REG_WE`, ADDR=7, DATA=0x5A, one cycle after the second strobe.
2. Port #1 write 0x34 then 0x52 → `o_VADDR_LD`, VADDR=0x1234, `o_VADDR_WR`=1. No `o_REG_WE`.
3. Port #1 0x3E→R#17. Then port #3 writes 0x11, 0x22, 0x33 → writes to R#62 (suppressed), R#63 (suppressed), R#0 with 0x33. Pointer ends at 1.
4. R#17=0x85 (AII=1). Then two port #3 writes → both land on R#5, pointer stays 5. A port #3 write with pointer=17 produces no WE.
5. Write R#9 with 0xFF → DATA=0xCE. Write R#15 with 0xFF → DATA=0xBF.
6. Port #1 0x12, then a port #1 read, then 0x87 → the sequence restarts: 0x87 is latched as a first byte and no WE occurs. Reset asserted between bytes behaves the same.
